// File: rtl/as_pkg.sv
// Shared types and constants for the operand-fetch slice.
package as_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  dvalid;
    logic [XLEN-1:0]       data;
  } fwd_src_t;

  // True when a producer stage will write the requested register.
  function automatic logic src_hit(input fwd_src_t src, input logic [REG_ADDR_W-1:0] rs);
    return src.we && (src.rd == rs);
  endfunction

endpackage

// File: rtl/as_fwd_mux.sv
// Per-operand bypass select: x0, then EX > MEM > WB, else regfile data.
module as_fwd_mux
  import as_pkg::*;
(
  input  fwd_src_t              ex_src,
  input  fwd_src_t              mem_src,
  input  fwd_src_t              wb_src,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]       rf_data,
  output logic [XLEN-1:0]       data_c,
  output logic                  hazard_c
);

  // The first matching stage wins; if its result is not ready, stall rather than fall through.
  always_comb begin
    data_c   = rf_data;
    hazard_c = 1'b0;
    if (rs == REG_ZERO) begin
      data_c = '0;
    end else if (src_hit(ex_src, rs)) begin
      data_c   = ex_src.data;
      hazard_c = !ex_src.dvalid;
    end else if (src_hit(mem_src, rs)) begin
      data_c   = mem_src.data;
      hazard_c = !mem_src.dvalid;
    end else if (src_hit(wb_src, rs)) begin
      data_c   = wb_src.data;
      hazard_c = !wb_src.dvalid;
    end
  end

endmodule

// File: rtl/as_operand_fetch.sv
// Operand-fetch stage: regfile read, RAW bypass, load-use stall and the ID->EX register.
module as_operand_fetch
  import as_pkg::*;
#(
  parameter int unsigned UOP_W = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [UOP_W-1:0]      id_uop_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_rd_we_i,
  output logic [REG_ADDR_W-1:0] rf_raddr01_o,
  output logic [REG_ADDR_W-1:0] rf_raddr02_o,
  input  logic [XLEN-1:0]       rf_rdata01_i,
  input  logic [XLEN-1:0]       rf_rdata02_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_we_i,
  input  logic                  ex_dvalid_i,
  input  logic [XLEN-1:0]       ex_data_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_we_i,
  input  logic                  mem_dvalid_i,
  input  logic [XLEN-1:0]       mem_data_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_we_i,
  input  logic                  wb_dvalid_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [UOP_W-1:0]      ex_uop_o,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_rd_we_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  fwd_src_t        ex_src, mem_src, wb_src;
  logic [XLEN-1:0] rs1_data_c, rs2_data_c;
  logic            rs1_hazard_c, rs2_hazard_c;
  logic            free_c, accept_c;

  assign rf_raddr01_o = id_rs1_i;
  assign rf_raddr02_o = id_rs2_i;

  assign ex_src  = '{rd: ex_rd_i,  we: ex_we_i,  dvalid: ex_dvalid_i,  data: ex_data_i};
  assign mem_src = '{rd: mem_rd_i, we: mem_we_i, dvalid: mem_dvalid_i, data: mem_data_i};
  assign wb_src  = '{rd: wb_rd_i,  we: wb_we_i,  dvalid: wb_dvalid_i,  data: wb_data_i};

  as_fwd_mux u_fwd_rs1 (
    .ex_src   (ex_src),
    .mem_src  (mem_src),
    .wb_src   (wb_src),
    .rs       (id_rs1_i),
    .rf_data  (rf_rdata01_i),
    .data_c   (rs1_data_c),
    .hazard_c (rs1_hazard_c)
  );

  as_fwd_mux u_fwd_rs2 (
    .ex_src   (ex_src),
    .mem_src  (mem_src),
    .wb_src   (wb_src),
    .rs       (id_rs2_i),
    .rf_data  (rf_rdata02_i),
    .data_c   (rs2_data_c),
    .hazard_c (rs2_hazard_c)
  );

  // A flush always drains decode so the killed instruction is discarded.
  assign free_c     = !ex_valid_o || ex_ready_i;
  assign id_ready_o = flush_i || (free_c && !(rs1_hazard_c || rs2_hazard_c));
  assign accept_c   = id_valid_i && id_ready_o && !flush_i;

  // ID->EX pipeline register; held untouched while EX back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_uop_o      <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_rd_o       <= '0;
      ex_rd_we_o    <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (accept_c) begin
      ex_valid_o    <= 1'b1;
      ex_pc_o       <= id_pc_i;
      ex_uop_o      <= id_uop_i;
      ex_rs1_data_o <= rs1_data_c;
      ex_rs2_data_o <= rs2_data_c;
      ex_rd_o       <= id_rd_i;
      ex_rd_we_o    <= id_rd_we_i && (id_rd_i != REG_ZERO);
    end else if (free_c) begin
      ex_valid_o <= 1'b0;
    end
  end

  // Saturating count of cycles decode was held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (id_valid_i && !id_ready_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
